alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake on both sides.
// Single-cycle ops (add/sub/logic/shift/rotate/compare) register their result
// on the accept edge; MULLO/MULHU run a WIDTH-cycle shift-add multiplier.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake; op, a, b sampled on accept
//   out_valid / out_ready result handshake; res and flags held while out_valid
//   res, flag_z/n/c/v     registered result and flags
//   busy                  multiplier iterating
module alu_mc #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;

  // Low while in reset and until the first clock edge afterwards, so in_ready
  // stays deasserted during reset even though state already reads IDLE.
  logic alive;

  logic accept;
  logic is_mul;

  // Multiplier state
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mcand;
  logic [SHW:0]       cnt;
  logic               mul_hi;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_last;

  // Single-cycle datapath
  logic [WIDTH:0]     sum_add;
  logic [WIDTH:0]     sum_sub;
  logic               v_add;
  logic               v_sub;
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] rot_l;
  logic [2*WIDTH-1:0] rot_r;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               alu_rsv;

  assign is_mul = (op == 4'b1100) || (op == 4'b1101);
  assign accept = in_valid & in_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = is_mul ? BUSY : DONE;
      BUSY: if (mul_last) state_nxt = DONE;
      DONE: begin
        if (accept)         state_nxt = is_mul ? BUSY : DONE;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = alive & ((state == IDLE) | ((state == DONE) & out_ready));
    out_valid = (state == DONE);
    busy      = (state == BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  // ---------------------------------------------------- single-cycle ALU
  always_comb begin
    sum_add = {1'b0, a} + {1'b0, b};
    sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    v_add   = (a[WIDTH-1] == b[WIDTH-1]) & (sum_add[WIDTH-1] != a[WIDTH-1]);
    v_sub   = (a[WIDTH-1] != b[WIDTH-1]) & (sum_sub[WIDTH-1] != a[WIDTH-1]);
    shamt   = b[SHW-1:0];
    dbl     = {a, a};
    rot_l   = dbl << shamt;
    rot_r   = dbl >> shamt;
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_rsv = 1'b0;
    unique case (op)
      4'b0000: begin alu_res = sum_add[WIDTH-1:0]; alu_c = sum_add[WIDTH]; alu_v = v_add; end
      4'b0001: begin alu_res = sum_sub[WIDTH-1:0]; alu_c = sum_sub[WIDTH]; alu_v = v_sub; end
      4'b0010: alu_res = a ^ b;
      4'b0011: alu_res = a & ~b;
      4'b0100: alu_res = rot_l[2*WIDTH-1:WIDTH];
      4'b0101: alu_res = a << shamt;
      4'b0110: alu_res = rot_r[WIDTH-1:0];
      4'b0111: alu_res = a >> shamt;
      4'b1000: alu_res = {{(WIDTH-1){1'b0}}, a == b};
      4'b1001: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'b1010: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) <= $signed(b)};
      4'b1011: alu_res = {{(WIDTH-1){1'b0}}, sum_add[WIDTH]};
      4'b1100, 4'b1101: alu_res = '0;
      default: alu_rsv = 1'b1;
    endcase
  end

  // ---------------------------------------------------------- multiplier
  // Right-shifting product register: low half starts as the multiplier and
  // is consumed LSB first while partial sums accumulate into the high half.
  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt = {mul_sum, prod[WIDTH-1:1]};
    mul_res  = mul_hi ? prod_nxt[2*WIDTH-1:WIDTH] : prod_nxt[WIDTH-1:0];
    mul_last = (state == BUSY) && (cnt == (SHW+1)'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod   <= '0;
      mcand  <= '0;
      cnt    <= '0;
      mul_hi <= 1'b0;
      res    <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        prod   <= {{WIDTH{1'b0}}, b};
        mcand  <= a;
        cnt    <= (SHW+1)'(WIDTH);
        mul_hi <= op[0];
      end else begin
        res    <= alu_res;
        // Reserved opcodes report all flags clear, including Z.
        flag_z <= ~alu_rsv & (alu_res == '0);
        flag_n <= alu_res[WIDTH-1];
        flag_c <= alu_c;
        flag_v <= alu_v;
      end
    end else if (state == BUSY) begin
      prod <= prod_nxt;
      cnt  <= cnt - (SHW+1)'(1);
      if (mul_last) begin
        res    <= mul_res;
        flag_z <= (mul_res == '0);
        flag_n <= mul_res[WIDTH-1];
        flag_c <= 1'b0;
        flag_v <= ~mul_hi & (|prod_nxt[2*WIDTH-1:WIDTH]);
      end
    end
  end

endmodule
